button_conditioner: RTL and testbench

Front-end input stage for the push-button sequence-detector FSM. It takes three raw, asynchronous, bouncing button inputs (A, B, C) and runs each through a synchronizer, a per-channel debounce state machine and a rising-edge detector. It produces clean debounced levels and single-cycle press pulses. The pulse outputs drive the FSM's A/B/C inputs directly, so each physical press yields exactly one registered event.

---
 rtl/button_conditioner.sv | 156 +++++++++++++++
 tb/tb_button_conditioner.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Three-channel push-button front end: per-channel synchronizer, debounce FSM
// and registered rising-edge pulse, plus a collision flag for simultaneous presses.
module button_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic A_RAW,
    input  logic B_RAW,
    input  logic C_RAW,
    output logic A_LVL,
    output logic B_LVL,
    output logic C_LVL,
    output logic A_PULSE,
    output logic B_PULSE,
    output logic C_PULSE,
    output logic COLLIDE
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } deb_state_t;

    logic [2:0] raw_vec;
    logic [2:0] lvl_vec;
    logic [2:0] pulse_vec;
    logic [2:0] pulse_next_vec;
    logic       collide_reg;
    logic       collide_next;

    assign raw_vec = {C_RAW, B_RAW, A_RAW};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   sync_q;
            deb_state_t             state_reg, state_next;
            logic [CW-1:0]          cnt_reg, cnt_next;
            logic                   lvl_reg, lvl_next;
            logic                   pulse_reg, pulse_next;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_vec[gi]};
                end
            end

            assign sync_q = sync_reg[SYNC_STAGES-1];

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    state_reg <= LOW;
                    cnt_reg   <= '0;
                    lvl_reg   <= 1'b0;
                    pulse_reg <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    lvl_reg   <= lvl_next;
                    pulse_reg <= pulse_next;
                end
            end

            // A level change is accepted only after DEBOUNCE_CYCLES consecutive
            // samples that disagree with the current level; any agreeing sample
            // drops back to the settled state.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                lvl_next   = lvl_reg;
                pulse_next = 1'b0;
                case (state_reg)
                    LOW: begin
                        if (sync_q) begin
                            state_next = CHK_HI;
                            cnt_next   = CNT_ONE;
                        end
                    end
                    CHK_HI: begin
                        if (!sync_q) begin
                            state_next = LOW;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = HIGH;
                            cnt_next   = '0;
                            lvl_next   = 1'b1;
                            pulse_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                    HIGH: begin
                        if (!sync_q) begin
                            state_next = CHK_LO;
                            cnt_next   = CNT_ONE;
                        end
                    end
                    CHK_LO: begin
                        if (sync_q) begin
                            state_next = HIGH;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = LOW;
                            cnt_next   = '0;
                            lvl_next   = 1'b0;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                    default: begin
                        state_next = LOW;
                        cnt_next   = '0;
                        lvl_next   = 1'b0;
                    end
                endcase
            end

            assign pulse_next_vec[gi] = pulse_next;
            assign lvl_vec[gi]        = lvl_reg;
            assign pulse_vec[gi]      = pulse_reg;
        end
    endgenerate

    // Two or more channels qualifying on the same edge.
    assign collide_next = (pulse_next_vec[0] & pulse_next_vec[1]) |
                          (pulse_next_vec[0] & pulse_next_vec[2]) |
                          (pulse_next_vec[1] & pulse_next_vec[2]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            collide_reg <= 1'b0;
        end else begin
            collide_reg <= collide_next;
        end
    end

    assign A_LVL   = lvl_vec[0];
    assign B_LVL   = lvl_vec[1];
    assign C_LVL   = lvl_vec[2];
    assign A_PULSE = pulse_vec[0];
    assign B_PULSE = pulse_vec[1];
    assign C_PULSE = pulse_vec[2];
    assign COLLIDE = collide_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// bouncing inputs, compared every cycle against a run-length debounce model.
module tb_button_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_raw = 1'b0, b_raw = 1'b0, c_raw = 1'b0;
    logic a_lvl, b_lvl, c_lvl, a_pulse, b_pulse, c_pulse, collide;

    int n_checks = 0;
    int n_fail   = 0;

    button_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
        .CLK(clk), .RST(rst),
        .A_RAW(a_raw), .B_RAW(b_raw), .C_RAW(c_raw),
        .A_LVL(a_lvl), .B_LVL(b_lvl), .C_LVL(c_lvl),
        .A_PULSE(a_pulse), .B_PULSE(b_pulse), .C_PULSE(c_pulse),
        .COLLIDE(collide)
    );

    always #5 clk = ~clk;

    // Reference model: sync_q is the raw value sampled SYNC edges earlier; a
    // level flips once DEB consecutive samples disagree with it.
    bit [2:0] mq[$];
    bit [2:0] m_lvl, m_pulse, m_s;
    bit       m_collide;
    int       m_run[3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_lvl = 3'b0; m_pulse = 3'b0; m_collide = 1'b0;
            for (int k = 0; k < 3; k++) m_run[k] = 0;
        end else begin
            m_s = (mq.size() >= SYNC) ? mq[mq.size() - SYNC] : 3'b0;
            mq.push_back({c_raw, b_raw, a_raw});
            if (mq.size() > 8) void'(mq.pop_front());
            m_pulse = 3'b0;
            for (int k = 0; k < 3; k++) begin
                if (m_s[k] != m_lvl[k]) m_run[k]++;
                else m_run[k] = 0;
                if (m_run[k] == DEB) begin
                    m_lvl[k]   = m_s[k];
                    m_pulse[k] = m_s[k];
                    m_run[k]   = 0;
                end
            end
            m_collide = ($countones(m_pulse) >= 2);
        end
    end

    logic [6:0] out_v, exp_v;
    assign out_v = {collide, c_pulse, b_pulse, a_pulse, c_lvl, b_lvl, a_lvl};
    assign exp_v = {m_collide, m_pulse, m_lvl};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        a_raw = 1'b0; b_raw = 1'b0; c_raw = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        a_raw = 1'b1; b_raw = 1'b1; c_raw = 1'b1;
        for (int e = 0; e < 6; e++) begin
            tick();
            n_checks++;
            if (out_v !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: got %b expected %b", e, out_v, 7'b0);
            end
        end
        a_raw = 1'b0; b_raw = 1'b0; c_raw = 1'b0;
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks++;
            if (out_v !== exp_v) begin
                n_fail++;
                $display("FAIL reset_release e%0d: got %b expected %b", e, out_v, exp_v);
            end
        end
    endtask

    task automatic test_clean_press();
        c_raw = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            n_checks++;
            if (out_v !== exp_v) begin
                n_fail++;
                $display("FAIL press_model e%0d: got %b expected %b", e, out_v, exp_v);
            end
            if (e == 5 || e == 6 || e == 7) begin
                n_checks++;
                if ({c_lvl, c_pulse} !== ((e == 5) ? 2'b00 : (e == 6) ? 2'b11 : 2'b10)) begin
                    n_fail++;
                    $display("FAIL press_c_lvl_pulse e%0d: got %b%b", e, c_lvl, c_pulse);
                end
            end
        end
        c_raw = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_checks++;
            if (out_v !== exp_v || c_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL release_model e%0d: got %b expected %b", e, out_v, exp_v);
            end
            if (e == 5 || e == 6) begin
                n_checks++;
                if (c_lvl !== (e == 5)) begin
                    n_fail++;
                    $display("FAIL release_c_lvl e%0d: got %b expected %b", e, c_lvl, (e == 5));
                end
            end
        end
    endtask

    task automatic test_bounce_press();
        int burst;
        int pulses;
        burst  = $urandom_range(1, DEB - 1);
        pulses = 0;
        b_raw = 1'b1;
        repeat (burst) begin
            tick();
            pulses += b_pulse;
        end
        b_raw = 1'b0;
        tick();
        pulses += b_pulse;
        b_raw = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            pulses += b_pulse;
            n_checks++;
            if (out_v !== exp_v) begin
                n_fail++;
                $display("FAIL bounce_model e%0d: got %b expected %b", e, out_v, exp_v);
            end
            if (e == 6) begin
                n_checks++;
                if (b_pulse !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bounce_b_pulse_e6: got %b expected 1", b_pulse);
                end
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL bounce_pulse_count: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_release_bounce();
        int wait_n;
        int pulses;
        wait_n = 0;
        pulses = 0;
        b_raw  = 1'b1;
        while (b_lvl !== 1'b1 && wait_n < 40) begin
            tick();
            wait_n++;
        end
        n_checks++;
        if (b_lvl !== 1'b1) begin
            n_fail++;
            $display("FAIL relbounce_wait_lvl: got %b expected 1 (timeout)", b_lvl);
        end
        b_raw = 1'b0;
        repeat (2) begin
            tick();
            pulses += b_pulse;
        end
        b_raw = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            pulses += b_pulse;
            n_checks++;
            if (out_v !== exp_v || b_lvl !== 1'b1) begin
                n_fail++;
                $display("FAIL relbounce_model e%0d: got %b expected %b", e, out_v, exp_v);
            end
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL relbounce_pulse_count: got %0d expected 0", pulses);
        end
        idle(12);
    endtask

    task automatic test_glitch();
        int len;
        len   = $urandom_range(1, DEB - 1);
        a_raw = 1'b1;
        repeat (len) tick();
        a_raw = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            n_checks++;
            if (out_v !== exp_v || {a_lvl, a_pulse, collide} !== 3'b000) begin
                n_fail++;
                $display("FAIL glitch e%0d len%0d: got %b expected %b", e, len, out_v, exp_v);
            end
        end
    endtask

    task automatic test_simultaneous();
        int n_coll;
        n_coll = 0;
        a_raw = 1'b1; c_raw = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            n_coll += collide;
            n_checks++;
            if (out_v !== exp_v) begin
                n_fail++;
                $display("FAIL simul_model e%0d: got %b expected %b", e, out_v, exp_v);
            end
            if (e == 6) begin
                n_checks++;
                if ({collide, c_pulse, b_pulse, a_pulse} !== 4'b1101) begin
                    n_fail++;
                    $display("FAIL simul_pulses_e6: got %b expected 1101",
                             {collide, c_pulse, b_pulse, a_pulse});
                end
            end
        end
        n_checks++;
        if (n_coll != 1) begin
            n_fail++;
            $display("FAIL simul_collide_count: got %0d expected 1", n_coll);
        end
        idle(12);
    endtask

    task automatic test_reset_mid();
        a_raw = 1'b1;
        repeat (8) tick();
        c_raw = 1'b1;
        repeat (3) tick();
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_v !== 7'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %b expected %b", out_v, 7'b0);
        end
        repeat (2) tick();
        n_checks++;
        if (out_v !== 7'b0) begin
            n_fail++;
            $display("FAIL rstmid_hold: got %b expected %b", out_v, 7'b0);
        end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks++;
            if (out_v !== exp_v) begin
                n_fail++;
                $display("FAIL rstmid_model e%0d: got %b expected %b", e, out_v, exp_v);
            end
            if (e == 5 || e == 6) begin
                n_checks++;
                if (c_pulse !== (e == 6)) begin
                    n_fail++;
                    $display("FAIL rstmid_c_pulse e%0d: got %b expected %b", e, c_pulse, (e == 6));
                end
            end
        end
        idle(12);
    endtask

    task automatic test_random();
        int hold[3];
        for (int k = 0; k < 3; k++) hold[k] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                if (hold[k] == 0) begin
                    hold[k] = $urandom_range(1, 2 * DEB + 1);
                    case (k)
                        0: a_raw = 1'($urandom_range(0, 1));
                        1: b_raw = 1'($urandom_range(0, 1));
                        default: c_raw = 1'($urandom_range(0, 1));
                    endcase
                end
                hold[k]--;
            end
            tick();
            n_checks++;
            if (out_v !== exp_v) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %b expected %b", cyc, out_v, exp_v);
            end
        end
        idle(12);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce_press();
        test_release_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
